bcd_serial_addsub: RTL
======================

Name: bcd_serial_addsub

Overview:
- Parametrised multi-digit packed-BCD adder/subtractor with true decimal correction, processing one digit per clock (least significant digit first).
- Next generation of the team's 4-bit-slice adders: configurable digit count, add/subtract mode, start/done handshake and an invalid-digit flag.
- Sits in the arithmetic library as a low-area decimal ALU for counters, displays and calculators.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=1); data width is 4*DIGITS.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- sub  in  1  0: A+B+cin; 1: A-B-cin (cin acts as borrow-in)
- a  in  4*DIGITS  packed BCD operand A, digit 0 in [3:0]
- b  in  4*DIGITS  packed BCD operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- ready  out  1  high in IDLE
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, result valid
- s  out  4*DIGITS  packed BCD result
- cout  out  1  decimal carry-out (add) / borrow-out (sub)
- invalid  out  1  some input digit of a or b was >9

Behaviour:
- Reset: state IDLE; ready=1, busy=0, done=0, s=0, cout=0, invalid=0; applies mid-operation, aborting with no done pulse.
- States: IDLE -> RUN on start&ready; RUN holds DIGITS cycles (digit counter 0..DIGITS-1) -> DONE; DONE holds 1 cycle -> IDLE. ready = (IDLE), busy = (RUN), done = (DONE).
- Accept edge: latch a, b (b replaced by nine's complement 9-b_i per digit when sub=1), sub; initial carry = cin when sub=0, ~cin when sub=1; invalid computed from raw a/b digits (any nibble >9) and latched.
- Each RUN cycle, for digit i: t = a_i + b'_i + c (5-bit). If t>9: digit = (t+6) mod 16, c=1; else digit = t, c=0. Rule is applied unchanged to invalid digits; result is deterministic, not meaningful.
- Final: cout = c when sub=0, ~c when sub=1. Subtraction with borrow yields ten's-complement result (0003-0005 -> 9998, cout=1).
- Latency: start high in cycle 0 -> done high in cycle DIGITS+1 -> ready high in cycle DIGITS+2. Throughput: one operation per DIGITS+2 cycles.
- s, cout, invalid update only on the DONE transition and hold until the next DONE or reset; they are never partially visible.
- start while not ready is ignored, not queued. Input changes after acceptance have no effect.
- DIGITS=1: RUN lasts one cycle; all rules unchanged.

Decomposition:
- Package bcd_pkg: state enum (IDLE, RUN, DONE), bcd_digit_t (logic[3:0]), constants BCD_MAX=9 and BCD_CORRECTION=6, function nines_complement.
- Sub-module bcd_digit_adder: combinational one-digit cell (a, b, cin -> s, cout, with correction). The top level holds the FSM, operand shift registers, result shift register and counter.

Test Plan (DIGITS=4):
- add a=1234, b=5678, cin=0 -> s=6912, cout=0, invalid=0; done exactly in cycle 5 after start cycle 0.
- add a=9999, b=0001, cin=0 -> s=0000, cout=1. add a=0999, b=0000, cin=1 -> s=1000, cout=0.
- sub a=0005, b=0003, cin=0 -> s=0002, cout=0. sub a=0003, b=0005 -> s=9998, cout=1. sub a=0000, b=0000, cin=1 -> s=9999, cout=1.
- invalid: a=0x00A0, b=0000, add -> invalid=1, s=0x0100, cout=0. Next valid op clears invalid.
- start pulsed during RUN is ignored (single done, result of first op). reset asserted in RUN cycle 2 -> no done, all outputs at reset values, ready=1 the next cycle.
- start held high continuously with changing operands -> done every 6 cycles; each result matches the operands sampled at its accept edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder/subtractor.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX        = 4'd9;
  localparam bcd_digit_t BCD_CORRECTION = 4'd6;

  // Nine's complement of one digit; digits above 9 simply wrap modulo 16.
  function automatic bcd_digit_t nines_complement(input bcd_digit_t d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit decimal adder cell: binary sum of two digits plus carry,
// corrected by +6 whenever the sum leaves the decimal range.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] t;

  // Raw 5-bit sum, then decimal correction with carry generation.
  always_comb begin
    t    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    s    = t[3:0];
    cout = 1'b0;
    if (t > {1'b0, BCD_MAX}) begin
      s    = t[3:0] + BCD_CORRECTION;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor working one digit per clock,
// least significant digit first. Subtraction adds the nine's complement
// of B with an inverted borrow, giving a ten's-complement result.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] s,
  output logic                cout,
  output logic                invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     a_sr;
  logic [W-1:0]     b_sr;
  logic [W-1:0]     res_sr;
  logic [W-1:0]     res_next;
  logic [W-1:0]     b_eff;
  logic             carry_q;
  logic             sub_q;
  logic             inv_q;
  logic             raw_invalid;
  logic             accept;
  logic             last_digit;
  logic [3:0]       dig_s;
  logic             dig_c;

  assign accept     = (state_q == IDLE) && start;
  assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_digit) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand preparation: flag out-of-range digits and complement B for subtraction.
  always_comb begin
    b_eff       = b;
    raw_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[4*i +: 4] > BCD_MAX) || (b[4*i +: 4] > BCD_MAX)) raw_invalid = 1'b1;
      if (sub) b_eff[4*i +: 4] = nines_complement(b[4*i +: 4]);
    end
  end

  bcd_digit_adder u_digit (
    .a    (a_sr[3:0]),
    .b    (b_sr[3:0]),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_c)
  );

  // New digit enters the result at the top so that after DIGITS shifts digit 0 sits in [3:0].
  assign res_next = (W'(dig_s) << (W - 4)) | (res_sr >> 4);

  // Datapath: latch on accept, shift one digit per RUN cycle, publish on the last digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      inv_q   <= 1'b0;
      s       <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      a_sr    <= a;
      b_sr    <= b_eff;
      res_sr  <= '0;
      carry_q <= sub ? ~cin : cin;
      sub_q   <= sub;
      inv_q   <= raw_invalid;
    end else if (state_q == RUN) begin
      cnt_q   <= cnt_q + CNT_W'(1);
      a_sr    <= a_sr >> 4;
      b_sr    <= b_sr >> 4;
      res_sr  <= res_next;
      carry_q <= dig_c;
      if (last_digit) begin
        s       <= res_next;
        cout    <= sub_q ? ~dig_c : dig_c;
        invalid <= inv_q;
      end
    end
  end

endmodule
